// File: rtl/ascii_uart_tx_pkg.sv
// Shared definitions for the ASCII UART transmitter slice.
//   ASCII_CR / ASCII_LF : line terminator bytes appended after the digits
//   ASCII_OFFSET        : '0' code point, for producers that build digits
//   ST_*                : serialiser FSM state encoding
//   digits_t            : latched tens/ones digit pair
//   clks_per_bit()      : baud divider derived from clock and line rate
package ascii_uart_tx_pkg;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam int         ASCII_OFFSET = 48;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef struct packed {
        logic [7:0] d10;
        logic [7:0] d1;
    } digits_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/ascii_uart_tx_if.sv
// Request/status bundle between a digit producer and ascii_uart_tx.
//   start   : single-cycle send request
//   d10/d1  : ASCII tens / ones digit
//   busy    : message in flight
//   done    : one-cycle pulse when the last stop bit completes
//   tx      : UART serial line (idle high)
// master = producer side, slave = transmitter side.
interface ascii_uart_tx_if;
    logic       start;
    logic [7:0] d10;
    logic [7:0] d1;
    logic       busy;
    logic       done;
    logic       tx;

    modport master (output start, d10, d1, input  busy, done, tx);
    modport slave  (input  start, d10, d1, output busy, done, tx);
endinterface

// File: rtl/ascii_uart_tx_uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, registered tx output.
//   clock, reset_n : clock and synchronous active-low reset
//   valid/data     : byte offered by the sequencer
//   ready          : byte accepted on this edge when valid is also high;
//                    high in IDLE and in the final cycle of a stop bit so
//                    back-to-back bytes have no idle gap
//   tx             : serial line
module uart_tx_byte
    import ascii_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int             CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == LAST_CNT);
    assign ready   = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else if (ready && valid) begin
            // Start bit goes out on the same edge the byte is taken.
            state    <= ST_START;
            shreg    <= data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= ST_STOP;
                            bit_idx <= '0;
                            tx      <= 1'b1;
                        end else begin
                            // tx takes the bit that lands in shreg[0] next.
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ascii_uart_tx.sv
// Message sequencer: on an accepted start, latches the two ASCII digits and
// streams d10, d1 (then CR, LF when SEND_CRLF=1) through uart_tx_byte.
//   clock, reset_n : clock and synchronous active-low reset
//   bus (slave)    : start/d10/d1 in, busy/done/tx out
module ascii_uart_tx
    import ascii_uart_tx_pkg::*;
#(
    parameter int CLK_HZ    = 27000000,
    parameter int BAUD      = 115200,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic           clock,
    input  logic           reset_n,
    ascii_uart_tx_if.slave bus
);

    localparam int         CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [1:0] LAST_BYTE    = SEND_CRLF ? 2'd3 : 2'd1;

    digits_t    dig_q;
    logic [1:0] byte_idx;
    logic [1:0] next_idx;
    logic       busy_q;
    logic       done_q;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic [7:0] next_byte;
    logic       tx_line;

    assign next_idx = byte_idx + 2'd1;

    // While idle the first byte is fed straight from the inputs so the start
    // bit appears one cycle after start; later bytes come from the buffer.
    always_comb begin
        next_byte = dig_q.d1;
        case (next_idx)
            2'd2:    next_byte = ASCII_CR;
            2'd3:    next_byte = ASCII_LF;
            default: ;
        endcase
        byte_valid = bus.start;
        byte_data  = bus.d10;
        if (busy_q) begin
            byte_valid = (byte_idx != LAST_BYTE);
            byte_data  = next_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dig_q    <= '0;
            byte_idx <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (bus.start) begin
                    busy_q   <= 1'b1;
                    dig_q    <= '{d10: bus.d10, d1: bus.d1};
                    byte_idx <= '0;
                end
            end else if (byte_ready) begin
                // byte_ready while busy means a stop bit just finished.
                if (byte_idx == LAST_BYTE) begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= next_idx;
                end
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clock   (clock),
        .reset_n (reset_n),
        .valid   (byte_valid),
        .data    (byte_data),
        .ready   (byte_ready),
        .tx      (tx_line)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.tx   = tx_line;

endmodule
